// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM ramp scheduler and its step unit.
package pwm_pkg;

   localparam int unsigned LEVEL_W = 8;
   localparam int unsigned STEP_W  = 4;

   typedef enum logic [0:0] {
      StIdle,
      StUpdate
   } state_e;

   typedef logic [LEVEL_W-1:0] level_t;
   typedef logic [STEP_W-1:0]  step_t;

endpackage

// File: rtl/pwm_ramp_step.sv
// Saturating step-toward-target: moves a level by at most i_step toward
// i_target without overshooting. A zero step jumps straight to the target.
module pwm_ramp_step #(
   parameter int unsigned LEVEL_W = pwm_pkg::LEVEL_W
) (
   input  logic [LEVEL_W-1:0] i_level,
   input  logic [LEVEL_W-1:0] i_target,
   input  pwm_pkg::step_t     i_step,
   output logic [LEVEL_W-1:0] o_level
);
   import pwm_pkg::*;

   localparam int unsigned WideW = LEVEL_W + 1;

   logic [LEVEL_W:0] w_sum;
   logic [LEVEL_W:0] w_diff;
   logic [LEVEL_W:0] w_target_wide;

   // One extra bit so the sum cannot wrap and the difference exposes a borrow.
   assign w_target_wide = {1'b0, i_target};
   assign w_sum         = {1'b0, i_level} + WideW'(i_step);
   assign w_diff        = {1'b0, i_level} - WideW'(i_step);

   always_comb begin
      o_level = i_level;
      if (i_step == '0) begin
         o_level = i_target;
      end else if (i_level < i_target) begin
         o_level = (w_sum > w_target_wide) ? i_target : w_sum[LEVEL_W-1:0];
      end else if (i_level > i_target) begin
         o_level = (w_diff[LEVEL_W] || (w_diff < w_target_wide)) ? i_target
                                                                : w_diff[LEVEL_W-1:0];
      end
   end

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Per-channel level ramping: once per PWM period, channels are walked one per
// cycle through a single shared step unit toward their host-written targets.
module pwm_ramp_scheduler #(
   parameter int unsigned NUM_CH   = 3,
   parameter int unsigned LEVEL_W  = pwm_pkg::LEVEL_W,
   parameter int unsigned TICK_DIV = 255,
   localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [CH_W-1:0]           cfg_ch,
   input  logic [LEVEL_W-1:0]        cfg_target,
   input  pwm_pkg::step_t            cfg_step,
   output logic [NUM_CH*LEVEL_W-1:0] level_out,
   output logic [NUM_CH-1:0]         busy,
   output logic                      period_start
);
   import pwm_pkg::*;

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CntW-1:0]    r_tick_cnt;
   state_e             r_state;
   logic [CH_W-1:0]    r_ch_idx;
   logic [LEVEL_W-1:0] r_level  [NUM_CH];
   logic [LEVEL_W-1:0] r_target [NUM_CH];
   step_t              r_step   [NUM_CH];

   logic               w_tick;
   logic               w_cfg_fire;
   logic [LEVEL_W-1:0] w_next_level;

   assign w_tick       = (r_tick_cnt == CntW'(TICK_DIV - 1));
   assign period_start = w_tick && reset_n;
   assign cfg_ready    = (r_state == StIdle) && reset_n;
   // Out-of-range channels are accepted but never written.
   assign w_cfg_fire   = cfg_valid && cfg_ready && (32'(cfg_ch) < NUM_CH);

   pwm_ramp_step #(
      .LEVEL_W (LEVEL_W)
   ) u_step (
      .i_level  (r_level[r_ch_idx]),
      .i_target (r_target[r_ch_idx]),
      .i_step   (r_step[r_ch_idx]),
      .o_level  (w_next_level)
   );

   always_comb begin
      level_out = '0;
      busy      = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         level_out[k*LEVEL_W +: LEVEL_W] = r_level[k];
         busy[k]                         = (r_level[k] != r_target[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_tick_cnt <= '0;
         r_state    <= StIdle;
         r_ch_idx   <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            r_level[k]  <= '0;
            r_target[k] <= '0;
            r_step[k]   <= '0;
         end
      end else begin
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
         if (w_cfg_fire) begin
            r_target[cfg_ch] <= cfg_target;
            r_step[cfg_ch]   <= cfg_step;
         end
         unique case (r_state)
            StIdle: begin
               if (w_tick) begin
                  r_state  <= StUpdate;
                  r_ch_idx <= '0;
               end
            end
            StUpdate: begin
               r_level[r_ch_idx] <= w_next_level;
               if (r_ch_idx == CH_W'(NUM_CH - 1)) begin
                  r_state  <= StIdle;
                  r_ch_idx <= '0;
               end else begin
                  r_ch_idx <= r_ch_idx + 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule
